alu_exec_ctrl: RTL and testbench

- Sequencing stage directly upstream of the 8-bit ALU (ports i_a, i_b, i_aluOp, i_sub, i_shiftLeft, ce; results o_y, o_negative, o_zero).
- Accepts one ALU operation per valid/ready request and registers the operands and controls.
- Drives the ALU chip-enable for a programmable settle window, then latches the ALU result and flags.
- Presents the result on a valid/ready response port and holds the architectural N/Z flags register.

---
 rtl/alu_exec_ctrl_if.sv | 33 +++
 rtl/alu_exec_ctrl.sv | 103 ++++++++++
 tb/tb_alu_exec_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_exec_ctrl_if.sv
// Request/response handshake bundle between the issue logic and the ALU
// sequencing stage.
interface alu_exec_ctrl_if;
    logic       req_valid;
    logic       req_ready;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [1:0] req_alu_op;
    logic       req_sub;
    logic       req_shift_left;
    logic       req_set_flags;
    logic       resp_valid;
    logic       resp_ready;
    logic [7:0] result;
    logic       flag_negative;
    logic       flag_zero;

    modport master (
        output req_valid, req_a, req_b, req_alu_op,
        output req_sub, req_shift_left, req_set_flags,
        output resp_ready,
        input  req_ready, resp_valid, result,
        input  flag_negative, flag_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_alu_op,
        input  req_sub, req_shift_left, req_set_flags,
        input  resp_ready,
        output req_ready, resp_valid, result,
        output flag_negative, flag_zero
    );
endinterface

// File: rtl/alu_exec_ctrl.sv
// Sequencing stage in front of the 8-bit ALU: registers one request, holds
// ce for a settle window, latches result and N/Z flags, returns a response.
module alu_exec_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    alu_exec_ctrl_if.slave       bus,
    output logic [7:0]           o_aluA,
    output logic [7:0]           o_aluB,
    output logic [1:0]           o_aluOp,
    output logic                 o_aluSub,
    output logic                 o_aluShiftLeft,
    output logic                 o_aluCe,
    input  logic [7:0]           i_aluY,
    input  logic                 i_aluNegative,
    input  logic                 i_aluZero
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_INIT = 4'(SETTLE_CYCLES - 1);

    logic [1:0] state;
    logic [3:0] cnt;
    logic [7:0] a_q;
    logic [7:0] b_q;
    logic [1:0] op_q;
    logic       sub_q;
    logic       shl_q;
    logic       setf_q;
    logic [7:0] result_q;
    logic       flag_n_q;
    logic       flag_z_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= 4'd0;
            a_q      <= 8'd0;
            b_q      <= 8'd0;
            op_q     <= 2'd0;
            sub_q    <= 1'b0;
            shl_q    <= 1'b0;
            setf_q   <= 1'b0;
            result_q <= 8'd0;
            flag_n_q <= 1'b0;
            flag_z_q <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.req_valid) begin
                        a_q    <= bus.req_a;
                        b_q    <= bus.req_b;
                        op_q   <= bus.req_alu_op;
                        sub_q  <= bus.req_sub;
                        shl_q  <= bus.req_shift_left;
                        setf_q <= bus.req_set_flags;
                        cnt    <= CNT_INIT;
                        state  <= EXEC;
                    end
                end
                EXEC: begin
                    // ce is high for this whole state, so the bus is driven
                    if (cnt == 4'd0) begin
                        result_q <= i_aluY;
                        if (setf_q) begin
                            flag_n_q <= i_aluNegative;
                            flag_z_q <= i_aluZero;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (bus.resp_ready) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.req_ready     = (state == IDLE);
    assign bus.resp_valid    = (state == RESP);
    assign bus.result        = result_q;
    assign bus.flag_negative = flag_n_q;
    assign bus.flag_zero     = flag_z_q;

    assign o_aluCe        = (state == EXEC);
    assign o_aluA         = a_q;
    assign o_aluB         = b_q;
    assign o_aluOp        = op_q;
    assign o_aluSub       = sub_q;
    assign o_aluShiftLeft = shl_q;

endmodule

// File: tb/tb_alu_exec_ctrl.sv
// Scoreboard bench for alu_exec_ctrl: two instances (settle 1 and 3), each
// with a behavioural 8-bit ALU on its tri-stated result bus.
module tb_alu_exec_ctrl;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       sel;
    logic       req_valid;
    logic [7:0] req_a;
    logic [7:0] req_b;
    logic [1:0] req_op;
    logic       req_sub;
    logic       req_shl;
    logic       req_setf;
    logic       resp_ready;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [7:0] res;
        logic       n;
        logic       z;
    } exp_t;

    exp_t sb[$];
    logic exp_n [2];
    logic exp_z [2];

    function automatic logic [7:0] alu_f(
        input logic [7:0] a,
        input logic [7:0] b,
        input logic [1:0] op,
        input logic       sub,
        input logic       shl
    );
        case (op)
            2'b00:   alu_f = sub ? a - b : a + b;
            2'b01:   alu_f = a & b;
            2'b10:   alu_f = a ^ b;
            default: alu_f = shl ? a << b[2:0] : a >> b[2:0];
        endcase
    endfunction

    alu_exec_ctrl_if bus1();
    alu_exec_ctrl_if bus3();

    assign bus1.req_valid      = req_valid & ~sel;
    assign bus3.req_valid      = req_valid & sel;
    assign bus1.resp_ready     = resp_ready & ~sel;
    assign bus3.resp_ready     = resp_ready & sel;
    assign bus1.req_a          = req_a;
    assign bus3.req_a          = req_a;
    assign bus1.req_b          = req_b;
    assign bus3.req_b          = req_b;
    assign bus1.req_alu_op     = req_op;
    assign bus3.req_alu_op     = req_op;
    assign bus1.req_sub        = req_sub;
    assign bus3.req_sub        = req_sub;
    assign bus1.req_shift_left = req_shl;
    assign bus3.req_shift_left = req_shl;
    assign bus1.req_set_flags  = req_setf;
    assign bus3.req_set_flags  = req_setf;

    logic [7:0] a1, b1, v1;
    logic [1:0] op1;
    logic       sub1, shl1, ce1;
    wire  [7:0] y1;
    assign v1 = alu_f(a1, b1, op1, sub1, shl1);
    assign y1 = ce1 ? v1 : 8'hzz;

    logic [7:0] a3, b3, v3;
    logic [1:0] op3;
    logic       sub3, shl3, ce3;
    wire  [7:0] y3;
    assign v3 = alu_f(a3, b3, op3, sub3, shl3);
    assign y3 = ce3 ? v3 : 8'hzz;

    alu_exec_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus1),
        .o_aluA         (a1),
        .o_aluB         (b1),
        .o_aluOp        (op1),
        .o_aluSub       (sub1),
        .o_aluShiftLeft (shl1),
        .o_aluCe        (ce1),
        .i_aluY         (y1),
        .i_aluNegative  (v1[7]),
        .i_aluZero      (v1 == 8'h00)
    );

    alu_exec_ctrl #(.SETTLE_CYCLES(3)) u_dut3 (
        .clk            (clk),
        .rst            (rst),
        .bus            (bus3),
        .o_aluA         (a3),
        .o_aluB         (b3),
        .o_aluOp        (op3),
        .o_aluSub       (sub3),
        .o_aluShiftLeft (shl3),
        .o_aluCe        (ce3),
        .i_aluY         (y3),
        .i_aluNegative  (v3[7]),
        .i_aluZero      (v3 == 8'h00)
    );

    logic       m_rdy, m_vld, m_ce, m_n, m_z;
    logic [7:0] m_res, m_alua;
    assign m_rdy  = sel ? bus3.req_ready     : bus1.req_ready;
    assign m_vld  = sel ? bus3.resp_valid    : bus1.resp_valid;
    assign m_res  = sel ? bus3.result        : bus1.result;
    assign m_n    = sel ? bus3.flag_negative : bus1.flag_negative;
    assign m_z    = sel ? bus3.flag_zero     : bus1.flag_zero;
    assign m_ce   = sel ? ce3 : ce1;
    assign m_alua = sel ? a3 : a1;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] op, input logic sub,
                         input logic shl, input logic setf);
        req_a     = a;
        req_b     = b;
        req_op    = op;
        req_sub   = sub;
        req_shl   = shl;
        req_setf  = setf;
        req_valid = 1'b1;
    endtask

    task automatic accept(input logic [7:0] res);
        int w = 0;
        while (!m_rdy && w < 50) begin
            @(negedge clk);
            w++;
        end
        chk("accept_wait", (w < 50) ? 32'd1 : 32'd0, 32'd1);
        @(posedge clk);
        if (req_setf) begin
            exp_n[sel] = res[7];
            exp_z[sel] = (res == 8'h00);
        end
        sb.push_back('{res: res, n: exp_n[sel], z: exp_z[sel]});
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic score();
        exp_t e;
        chk("sb_size", sb.size(), 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("result", m_res, e.res);
            chk("flag_n", m_n, e.n);
            chk("flag_z", m_z, e.z);
        end
    endtask

    task automatic finish_op(input int settle);
        int cyc = 0;
        int ce_n = 0;
        while (!m_vld && cyc < 40) begin
            if (m_ce) ce_n++;
            @(negedge clk);
            cyc++;
        end
        chk("latency", cyc, settle);
        chk("ce_cycles", ce_n, settle);
        chk("ce_low_resp", m_ce, 1'b0);
        score();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("resp_drop", m_vld, 1'b0);
        chk("idle_ready", m_rdy, 1'b1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        sel        = 1'b0;
        req_valid  = 1'b0;
        req_a      = 8'd0;
        req_b      = 8'd0;
        req_op     = 2'd0;
        req_sub    = 1'b0;
        req_shl    = 1'b0;
        req_setf   = 1'b0;
        resp_ready = 1'b0;
        exp_n[0] = 1'b0; exp_n[1] = 1'b0;
        exp_z[0] = 1'b0; exp_z[1] = 1'b0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        for (int s = 0; s < 2; s++) begin
            sel = s[0];
            #1;
            chk("rst_ready", m_rdy, 1'b1);
            chk("rst_valid", m_vld, 1'b0);
            chk("rst_ce", m_ce, 1'b0);
            chk("rst_result", m_res, 8'h00);
            chk("rst_n", m_n, 1'b0);
            chk("rst_z", m_z, 1'b0);
            chk("rst_alua", m_alua, 8'h00);
        end
        sel = 1'b0;
        @(negedge clk);

        drive(8'd20, 8'd22, 2'b00, 1'b0, 1'b0, 1'b1);
        accept(8'd42);
        finish_op(1);
        drive(8'd200, 8'd56, 2'b00, 1'b0, 1'b0, 1'b1);
        accept(8'h00);
        finish_op(1);
        drive(8'd15, 8'd42, 2'b00, 1'b1, 1'b0, 1'b1);
        accept(8'hE5);
        finish_op(1);
        drive(8'd42, 8'd15, 2'b00, 1'b1, 1'b0, 1'b0);
        accept(8'd27);
        finish_op(1);

        drive(8'h0F, 8'hF0, 2'b10, 1'b0, 1'b0, 1'b0);
        accept(8'hFF);
        for (int i = 0; i < 10 && !m_vld; i++) @(negedge clk);
        chk("bp_valid", m_vld, 1'b1);
        drive(8'd3, 8'd4, 2'b00, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_ready", m_rdy, 1'b0);
            chk("bp_result", m_res, 8'hFF);
            chk("bp_ce", m_ce, 1'b0);
            chk("bp_alua", m_alua, 8'h0F);
        end
        score();
        resp_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        resp_ready = 1'b0;
        chk("bp_idle_ready", m_rdy, 1'b1);
        chk("bp_idle_valid", m_vld, 1'b0);
        chk("bp_idle_ce", m_ce, 1'b0);
        accept(8'd7);
        chk("bp_pending_ce", m_ce, 1'b1);
        chk("bp_pending_a", m_alua, 8'd3);
        finish_op(1);

        sel = 1'b1;
        @(negedge clk);
        drive(8'h2A, 8'd3, 2'b11, 1'b0, 1'b1, 1'b1);
        accept(8'h50);
        finish_op(3);
        drive(8'h2A, 8'd1, 2'b11, 1'b0, 1'b0, 1'b1);
        accept(8'h15);
        finish_op(3);
        drive(8'h2A, 8'd2, 2'b11, 1'b0, 1'b1, 1'b1);
        accept(8'hA8);
        finish_op(3);

        drive(8'h2A, 8'h0F, 2'b01, 1'b0, 1'b0, 1'b1);
        accept(8'h0A);
        @(negedge clk);
        chk("mid_exec_ce", m_ce, 1'b1);
        rst = 1'b1;
        #1;
        chk("abort_ce", m_ce, 1'b0);
        chk("abort_valid", m_vld, 1'b0);
        chk("abort_ready", m_rdy, 1'b1);
        chk("abort_n", m_n, 1'b0);
        chk("abort_z", m_z, 1'b0);
        chk("abort_result", m_res, 8'h00);
        sb.delete();
        exp_n[0] = 1'b0; exp_n[1] = 1'b0;
        exp_z[0] = 1'b0; exp_z[1] = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        drive(8'h2A, 8'h0F, 2'b01, 1'b0, 1'b0, 1'b1);
        accept(8'h0A);
        finish_op(3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
